// File: rtl/stall_mem_model.sv
// -----------------------------------------------------------------------------
// stall_mem_model
//   Behavioural single-port SRAM with a grant/stall handshake. It stands in for
//   the memory behind an AXI memory interface in test harnesses. A free-running
//   period counter opens a busy window of BUSY_LEN cycles at the end of every
//   BUSY_PERIOD cycles. Requests are refused while the window is open. Writes
//   honour per-lane byte enables. Reads return after READ_LAT cycles with a
//   one-cycle valid strobe.
//
// Handshake: a request is (CEN_o == 0) at a rising edge. It is accepted when
//   MGRANT_i is high at that edge and refused otherwise. MGRANT_i depends only
//   on the internal period counter, so a requester may look at it before it
//   decides to drive a request. A refused request has no effect apart from
//   stall_cnt. The requester re-issues it itself.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   MGRANT_i   grant (1 = a request at the next edge is accepted)
//   CEN_o      chip enable, active-low
//   WEN_o      0 = write, 1 = read
//   A_o        word address
//   D_o        write data
//   BE_o       per-lane byte enables, active-high
//   Q_i        read data; holds the last returned word between reads
//   QVALID_i   Q_i carries a read that completes this cycle
//   acc_cnt    accepted accesses, saturating at 16'hFFFF
//   stall_cnt  refused requests, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module stall_mem_model #(
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI_NUMBYTES    = AXI4_DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH  = 13,
  parameter int READ_LAT        = 1,
  parameter int BUSY_PERIOD     = 16,
  parameter int BUSY_LEN        = 4,
  parameter bit STALL_EN        = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       MGRANT_i,
  input  logic                       CEN_o,
  input  logic                       WEN_o,
  input  logic [MEM_ADDR_WIDTH-1:0]  A_o,
  input  logic [AXI4_DATA_WIDTH-1:0] D_o,
  input  logic [AXI_NUMBYTES-1:0]    BE_o,
  output logic [AXI4_DATA_WIDTH-1:0] Q_i,
  output logic                       QVALID_i,
  output logic [15:0]                acc_cnt,
  output logic [15:0]                stall_cnt
);

  localparam int DEPTH   = 2 ** MEM_ADDR_WIDTH;
  localparam int CNT_W   = (BUSY_PERIOD > 2) ? $clog2(BUSY_PERIOD) : 1;
  // Number of address stages ahead of the array read. With READ_LAT == 1 the
  // array is read straight from the request and the single stage is unused.
  localparam int PIPE_D  = (READ_LAT > 1) ? READ_LAT - 1 : 1;
  localparam int OUT_IDX = PIPE_D - 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BUSY_PERIOD - 1);
  localparam logic [CNT_W-1:0] BUSY_START = CNT_W'(BUSY_PERIOD - BUSY_LEN);

  // Elaboration-time parameter checks.
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $fatal(1, "stall_mem_model: READ_LAT must be in 1..4");
  end
  if (BUSY_PERIOD < 2 || BUSY_LEN < 0 || BUSY_LEN >= BUSY_PERIOD) begin : g_bad_busy
    $fatal(1, "stall_mem_model: need BUSY_PERIOD >= 2 and 0 <= BUSY_LEN < BUSY_PERIOD");
  end
  if (AXI4_DATA_WIDTH % 8 != 0 || AXI_NUMBYTES * 8 != AXI4_DATA_WIDTH) begin : g_bad_width
    $fatal(1, "stall_mem_model: data width must be a multiple of 8 with one byte per lane");
  end

  // Storage. The array is not reset.
  logic [AXI4_DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PIPE_D-1:0]          pv_q, pv_d;
  logic [MEM_ADDR_WIDTH-1:0]  pa_q [PIPE_D];
  logic [MEM_ADDR_WIDTH-1:0]  pa_d [PIPE_D];
  logic [AXI4_DATA_WIDTH-1:0] q_q, q_d;
  logic                       qvalid_q, qvalid_d;
  logic [15:0]                acc_cnt_q, acc_cnt_d;
  logic [15:0]                stall_cnt_q, stall_cnt_d;

  logic                       busy;
  logic                       acc, acc_wr, acc_rd;
  logic                       out_v;
  logic [MEM_ADDR_WIDTH-1:0]  out_a;
  logic [AXI4_DATA_WIDTH-1:0] rd_word;

  // The busy window sits at the top of the period. During reset cnt_q is 0,
  // so the grant stays high.
  always_comb begin
    busy = STALL_EN && (BUSY_LEN != 0) && (cnt_q >= BUSY_START);
  end

  assign MGRANT_i = ~busy;

  always_comb begin
    acc    = ~CEN_o & ~busy;
    acc_wr = acc & ~WEN_o;
    acc_rd = acc & WEN_o;
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    // Shift the read-address pipeline. Stage 0 captures the new read.
    pv_d    = pv_q;
    pa_d    = pa_q;
    pv_d[0] = acc_rd;
    pa_d[0] = A_o;
    for (int i = 1; i < PIPE_D; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end

    // The array is read at the pipeline output.
    if (READ_LAT == 1) begin
      out_v = acc_rd;
      out_a = A_o;
    end else begin
      out_v = pv_q[OUT_IDX];
      out_a = pa_q[OUT_IDX];
    end

    // A write accepted on the same edge as a late read of the same word is
    // merged in, so the read sees the memory as it stands after that edge.
    // This cannot happen with READ_LAT == 1: that edge already carries the
    // read itself.
    rd_word = mem[out_a];
    if (acc_wr && (A_o == out_a)) begin
      for (int i = 0; i < AXI_NUMBYTES; i++) begin
        if (BE_o[i]) rd_word[i*8 +: 8] = D_o[i*8 +: 8];
      end
    end

    q_d      = out_v ? rd_word : q_q;
    qvalid_d = out_v;

    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (acc && (acc_cnt_q != 16'hFFFF)) acc_cnt_d = acc_cnt_q + 16'd1;
    if (~CEN_o && busy && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      pv_q        <= '0;
      for (int i = 0; i < PIPE_D; i++) pa_q[i] <= '0;
      q_q         <= '0;
      qvalid_q    <= 1'b0;
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
      pa_q        <= pa_d;
      q_q         <= q_d;
      qvalid_q    <= qvalid_d;
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int i = 0; i < AXI_NUMBYTES; i++) begin
        if (BE_o[i]) mem[A_o][i*8 +: 8] <= D_o[i*8 +: 8];
      end
    end
  end

  assign Q_i       = q_q;
  assign QVALID_i  = qvalid_q;
  assign acc_cnt   = acc_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_mem_model.sv
module tb_stall_mem_model;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus into all instances
  logic        cen = 1'b1;
  logic        wen = 1'b1;
  logic [12:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  // per-instance outputs: 0 default, 1 READ_LAT=3, 2 READ_LAT=4, 3 STALL_EN=0
  logic [3:0]  grant_w, qv_w;
  logic [31:0] q_w [4];
  logic [15:0] acc_w [4];
  logic [15:0] stl_w [4];

  stall_mem_model u_def (
    .clk(clk), .rst(rst), .MGRANT_i(grant_w[0]), .CEN_o(cen), .WEN_o(wen), .A_o(addr),
    .D_o(wdata), .BE_o(be), .Q_i(q_w[0]), .QVALID_i(qv_w[0]), .acc_cnt(acc_w[0]), .stall_cnt(stl_w[0]));
  stall_mem_model #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .MGRANT_i(grant_w[1]), .CEN_o(cen), .WEN_o(wen), .A_o(addr),
    .D_o(wdata), .BE_o(be), .Q_i(q_w[1]), .QVALID_i(qv_w[1]), .acc_cnt(acc_w[1]), .stall_cnt(stl_w[1]));
  stall_mem_model #(.READ_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .MGRANT_i(grant_w[2]), .CEN_o(cen), .WEN_o(wen), .A_o(addr),
    .D_o(wdata), .BE_o(be), .Q_i(q_w[2]), .QVALID_i(qv_w[2]), .acc_cnt(acc_w[2]), .stall_cnt(stl_w[2]));
  stall_mem_model #(.STALL_EN(1'b0)) u_nostall (
    .clk(clk), .rst(rst), .MGRANT_i(grant_w[3]), .CEN_o(cen), .WEN_o(wen), .A_o(addr),
    .D_o(wdata), .BE_o(be), .Q_i(q_w[3]), .QVALID_i(qv_w[3]), .acc_cnt(acc_w[3]), .stall_cnt(stl_w[3]));

  logic [1:0]  sel = 2'd0;
  logic        obs_grant, obs_qvalid;
  logic [31:0] obs_q;
  logic [15:0] obs_acc, obs_stall;
  always_comb begin
    obs_grant  = grant_w[sel];
    obs_qvalid = qv_w[sel];
    obs_q      = q_w[sel];
    obs_acc    = acc_w[sel];
    obs_stall  = stl_w[sel];
  end

  int errors = 0;
  int checks = 0;

  // reference model: cycle index since reset release, byte-addressed memory
  // image and a list of reads with the edge at which each one completes
  int          m_k, m_lat, m_acc, m_stall;
  bit          m_stall_en;
  logic [31:0] m_mem [int];
  int          pend_a[$];
  int          pend_due[$];
  logic        exp_grant, exp_qvalid, g_obs;
  logic [31:0] exp_q;
  logic [31:0] exp_q_q[$];

  task automatic model_reset();
    m_k = 0; m_acc = 0; m_stall = 0;
    pend_a.delete(); pend_due.delete(); exp_q_q.delete();
    exp_qvalid = 1'b0; exp_q = '0;
  endtask

  task automatic select_dut(input int s);
    sel = 2'(s);
    m_lat = (s == 1) ? 3 : (s == 2) ? 4 : 1;
    m_stall_en = (s != 3);
    m_mem.delete();
  endtask

  // Reset released 1ns after a rising edge: the next edge is cycle 0.
  task automatic apply_reset();
    @(negedge clk);
    cen = 1'b1; wen = 1'b1; be = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus. The grant is sampled at the falling edge before the
  // active edge; the model then advances and outputs are sampled 1ns after it.
  task automatic drive_cycle(input logic c, input logic w, input int a,
                             input logic [31:0] d, input logic [3:0] be_i);
    logic        acc;
    logic [31:0] word;
    @(negedge clk);
    cen = c; wen = w; addr = a[12:0]; wdata = d; be = be_i;
    #1 g_obs = obs_grant;
    exp_grant = !(m_stall_en && ((m_k % 16) >= 12));
    acc = !c && exp_grant;
    @(posedge clk);
    if (!c && !exp_grant && m_stall < 65535) m_stall++;
    if (acc && m_acc < 65535) m_acc++;
    if (acc && !w) begin
      if (!m_mem.exists(a)) m_mem[a] = 'x;
      word = m_mem[a];
      for (int i = 0; i < 4; i++) if (be_i[i]) word[i*8 +: 8] = d[i*8 +: 8];
      m_mem[a] = word;
    end
    if (acc && w) begin
      pend_a.push_back(a);
      pend_due.push_back(m_k + m_lat - 1);
    end
    exp_qvalid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == m_k) begin
      exp_q = m_mem[pend_a[0]];
      exp_qvalid = 1'b1;
      exp_q_q.push_back(exp_q);
      void'(pend_a.pop_front());
      void'(pend_due.pop_front());
    end
    m_k++;
    #1;
  endtask

  task automatic test_reset();
    select_dut(0);
    @(negedge clk);
    rst = 1'b1; cen = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks += 5;
      if (obs_grant !== 1'b1) begin errors++; $display("FAIL reset_grant got=%b want=1", obs_grant); end
      if (obs_qvalid !== 1'b0) begin errors++; $display("FAIL reset_qvalid got=%b want=0", obs_qvalid); end
      if (obs_q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h want=0", obs_q); end
      if (obs_acc !== 16'h0) begin errors++; $display("FAIL reset_acc got=%0d want=0", obs_acc); end
      if (obs_stall !== 16'h0) begin errors++; $display("FAIL reset_stall got=%0d want=0", obs_stall); end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_grant_pattern();
    select_dut(0);
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
      checks++;
      if (g_obs !== exp_grant) begin errors++; $display("FAIL grant_pattern cyc=%0d got=%b want=%b", n, g_obs, exp_grant); end
    end
    checks += 2;
    if (obs_acc !== 16'd0) begin errors++; $display("FAIL grant_acc got=%0d want=0", obs_acc); end
    if (obs_stall !== 16'd0) begin errors++; $display("FAIL grant_stall got=%0d want=0", obs_stall); end
  endtask

  task automatic test_byte_enable();
    select_dut(0);
    apply_reset();
    drive_cycle(1'b0, 1'b0, 5, 32'hAABBCCDD, 4'hF);
    drive_cycle(1'b0, 1'b0, 5, 32'h11223344, 4'b0101);
    drive_cycle(1'b0, 1'b1, 5, 32'h0, 4'h0);
    checks += 2;
    if (obs_qvalid !== 1'b1) begin errors++; $display("FAIL be_qvalid got=%b want=1", obs_qvalid); end
    if (obs_q !== 32'hAA22CC44) begin errors++; $display("FAIL be_data got=%h want=aa22cc44", obs_q); end
    drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
    checks += 2;
    if (obs_qvalid !== 1'b0) begin errors++; $display("FAIL be_qvalid_drop got=%b want=0", obs_qvalid); end
    if (obs_q !== 32'hAA22CC44) begin errors++; $display("FAIL be_hold got=%h want=aa22cc44", obs_q); end
  endtask

  task automatic test_latency();
    int first_edge, pulses;
    logic [31:0] seen [3];
    select_dut(1);
    apply_reset();
    for (int i = 1; i <= 3; i++) drive_cycle(1'b0, 1'b0, i, 32'(i * 16), 4'hF);
    first_edge = -1; pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (n < 3) drive_cycle(1'b0, 1'b1, n + 1, 32'h0, 4'h0);
      else drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
      checks += 2;
      if (obs_qvalid !== exp_qvalid) begin errors++; $display("FAIL lat_qvalid edge=%0d got=%b want=%b", m_k - 1, obs_qvalid, exp_qvalid); end
      if (obs_q !== exp_q) begin errors++; $display("FAIL lat_data edge=%0d got=%h want=%h", m_k - 1, obs_q, exp_q); end
      if (obs_qvalid === 1'b1) begin
        if (first_edge < 0) first_edge = m_k - 1;
        if (pulses < 3) seen[pulses] = obs_q;
        pulses++;
      end
    end
    // reads at edges 3,4,5 -> completions at edges 5,6,7
    checks += 5;
    if (first_edge != 5) begin errors++; $display("FAIL lat_first_edge got=%0d want=5", first_edge); end
    if (pulses != 3) begin errors++; $display("FAIL lat_pulses got=%0d want=3", pulses); end
    if (seen[0] !== 32'h10 || seen[1] !== 32'h20) begin errors++; $display("FAIL lat_order got=%h,%h want=10,20", seen[0], seen[1]); end
    if (seen[2] !== 32'h30) begin errors++; $display("FAIL lat_third got=%h want=30", seen[2]); end
    if (obs_q !== 32'h30) begin errors++; $display("FAIL lat_hold got=%h want=30", obs_q); end
  endtask

  task automatic test_stall();
    int pulses;
    select_dut(0);
    apply_reset();
    drive_cycle(1'b0, 1'b0, 7, 32'hCAFE0007, 4'hF);
    apply_reset();
    for (int n = 0; n < 10; n++) drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      if (n < 8) drive_cycle(1'b0, 1'b1, 7, 32'h0, 4'h0);
      else drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
      checks += 3;
      if (g_obs !== exp_grant) begin errors++; $display("FAIL stall_grant edge=%0d got=%b want=%b", m_k - 1, g_obs, exp_grant); end
      if (obs_qvalid !== exp_qvalid) begin errors++; $display("FAIL stall_qvalid edge=%0d got=%b want=%b", m_k - 1, obs_qvalid, exp_qvalid); end
      if (obs_q !== exp_q) begin errors++; $display("FAIL stall_data edge=%0d got=%h want=%h", m_k - 1, obs_q, exp_q); end
      if (obs_qvalid === 1'b1) pulses++;
      if (n == 1) begin
        // read accepted at cnt 11 returns while cnt 12 is busy
        checks++;
        if (!(obs_qvalid === 1'b1 && obs_grant === 1'b0 && obs_q === 32'hCAFE0007)) begin
          errors++; $display("FAIL stall_busy_return got qv=%b grant=%b q=%h want qv=1 grant=0 q=cafe0007", obs_qvalid, obs_grant, obs_q);
        end
      end
    end
    checks += 3;
    if (obs_acc !== 16'd4) begin errors++; $display("FAIL stall_acc got=%0d want=4", obs_acc); end
    if (obs_stall !== 16'd4) begin errors++; $display("FAIL stall_cnt got=%0d want=4", obs_stall); end
    if (pulses != 4) begin errors++; $display("FAIL stall_pulses got=%0d want=4", pulses); end
  endtask

  task automatic test_reset_mid_read();
    select_dut(2);
    apply_reset();
    drive_cycle(1'b0, 1'b0, 9, 32'h5A5A1234, 4'hF);
    drive_cycle(1'b0, 1'b1, 9, 32'h0, 4'h0);
    drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
    drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks += 3;
      if (obs_grant !== 1'b1) begin errors++; $display("FAIL mid_rst_grant got=%b want=1", obs_grant); end
      if (obs_qvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_qvalid got=%b want=0", obs_qvalid); end
      if (obs_acc !== 16'd0 || obs_stall !== 16'd0) begin errors++; $display("FAIL mid_rst_counters got=%0d/%0d want=0/0", obs_acc, obs_stall); end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 12; n++) begin
      if (n == 5) drive_cycle(1'b0, 1'b1, 9, 32'h0, 4'h0);
      else drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
      checks += 2;
      if (obs_qvalid !== exp_qvalid) begin errors++; $display("FAIL mid_after_qvalid edge=%0d got=%b want=%b", m_k - 1, obs_qvalid, exp_qvalid); end
      if (obs_q !== exp_q) begin errors++; $display("FAIL mid_after_data edge=%0d got=%h want=%h", m_k - 1, obs_q, exp_q); end
    end
    checks++;
    if (obs_q !== 32'h5A5A1234) begin errors++; $display("FAIL mid_readback got=%h want=5a5a1234", obs_q); end
  endtask

  task automatic test_random();
    int pulses;
    for (int s = 0; s < 3; s++) begin
      select_dut(s);
      apply_reset();
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, i, $urandom, 4'hF);
      pulses = 0;
      for (int n = 0; n < 260; n++) begin
        if (n < 250)
          drive_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      $urandom, 4'($urandom_range(0, 15)));
        else drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
        checks += 3;
        if (g_obs !== exp_grant) begin errors++; $display("FAIL rnd_grant dut=%0d edge=%0d got=%b want=%b", s, m_k - 1, g_obs, exp_grant); end
        if (obs_qvalid !== exp_qvalid) begin errors++; $display("FAIL rnd_qvalid dut=%0d edge=%0d got=%b want=%b", s, m_k - 1, obs_qvalid, exp_qvalid); end
        if (obs_q !== exp_q) begin errors++; $display("FAIL rnd_data dut=%0d edge=%0d got=%h want=%h", s, m_k - 1, obs_q, exp_q); end
        if (obs_qvalid === 1'b1) pulses++;
      end
      checks += 3;
      if (obs_acc !== 16'(m_acc)) begin errors++; $display("FAIL rnd_acc dut=%0d got=%0d want=%0d", s, obs_acc, m_acc); end
      if (obs_stall !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall dut=%0d got=%0d want=%0d", s, obs_stall, m_stall); end
      if (pulses != exp_q_q.size()) begin errors++; $display("FAIL rnd_pulses dut=%0d got=%0d want=%0d", s, pulses, exp_q_q.size()); end
    end
  endtask

  task automatic test_saturation();
    int grant_low;
    select_dut(3);
    apply_reset();
    drive_cycle(1'b0, 1'b0, 0, 32'h0BADF00D, 4'hF);
    grant_low = 0;
    for (int n = 0; n < 70002; n++) begin
      if (n < 70000) drive_cycle(1'b0, 1'b1, 0, 32'h0, 4'h0);
      else drive_cycle(1'b1, 1'b1, 0, 32'h0, 4'h0);
      if (g_obs !== 1'b1) grant_low++;
      if (obs_qvalid !== exp_qvalid || obs_q !== exp_q) begin
        errors++; $display("FAIL sat_read edge=%0d got qv=%b q=%h want qv=%b q=%h", m_k - 1, obs_qvalid, obs_q, exp_qvalid, exp_q);
      end
      checks++;
    end
    checks += 3;
    if (grant_low != 0) begin errors++; $display("FAIL sat_grant_low got=%0d want=0", grant_low); end
    if (obs_stall !== 16'd0) begin errors++; $display("FAIL sat_stall got=%0d want=0", obs_stall); end
    if (obs_acc !== 16'hFFFF) begin errors++; $display("FAIL sat_acc got=%h want=ffff", obs_acc); end
  endtask

  initial begin
    test_reset();
    test_grant_pattern();
    test_byte_enable();
    test_latency();
    test_stall();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time bound so the bench always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
